// File: rtl/soc2_nios_oci_trace_monitor.sv
// Trace capture monitor: a small FSM gates captures of {dct_count, dct_buffer} into a FIFO.
// Optional macro SOC2_OCI_TRACE_OVERWRITE_EN: a push into a full FIFO overwrites the oldest entry instead of being dropped.
module soc2_nios_oci_trace_monitor #(
  parameter int DATA_W  = 30,
  parameter int COUNT_W = 4,
  parameter int DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_W-1:0]            dct_buffer,
  input  logic [COUNT_W-1:0]           dct_count,
  input  logic                         dct_valid,
  input  logic                         test_ending,
  input  logic                         test_has_ended,
  input  logic                         rd_en,
  output logic [DATA_W+COUNT_W-1:0]    rd_data,
  output logic                         rd_valid,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow,
  output logic [1:0]                   state
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + COUNT_W;

`ifdef SOC2_OCI_TRACE_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     level_reg;
  logic            overflow_reg;
  logic            rd_valid_reg;
  logic [EW-1:0]   rd_data_reg;
  logic [EW-1:0]   mem [DEPTH];

  logic accept_ok;
  logic push, pop, push_full_no_pop;
  logic wr_en, rd_adv;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == (AW+1)'(DEPTH));

  always_comb begin
    state_next = state_reg;
    accept_ok  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        accept_ok = !test_ending && !test_has_ended;
        if (test_has_ended)   state_next = ST_DONE;
        else if (test_ending) state_next = ST_DRAIN;
        else if (dct_valid)   state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        accept_ok = !test_ending && !test_has_ended;
        if (test_has_ended)   state_next = ST_DONE;
        else if (test_ending) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (test_has_ended) state_next = ST_DONE;
      end
      default: state_next = ST_DONE;
    endcase
  end

  // A simultaneous pop frees a slot, so only a lone push into a full FIFO is an overflow.
  assign push             = dct_valid && accept_ok;
  assign pop              = rd_en && !empty;
  assign push_full_no_pop = push && full && !pop;
  assign wr_en            = push && (!push_full_no_pop || OVERWRITE);
  assign rd_adv           = pop || (push_full_no_pop && OVERWRITE);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {dct_count, dct_buffer};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (wr_en)  wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_adv) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (pop && !push)
        level_reg <= level_reg - (AW+1)'(1);
      else if (push && !pop && !full)
        level_reg <= level_reg + (AW+1)'(1);
      if (push_full_no_pop) overflow_reg <= 1'b1;
      rd_valid_reg <= pop;
      if (pop) rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign level    = level_reg;
  assign overflow = overflow_reg;
  assign state    = state_reg;

endmodule

// File: tb/tb_soc2_nios_oci_trace_monitor.sv
// Bench for soc2_nios_oci_trace_monitor: vector table, directed corner sequences, randomized run vs a queue model.
module tb_soc2_nios_oci_trace_monitor;

  localparam int DATA_W = 30;
  localparam int COUNT_W = 4;
  localparam int DEPTH = 16;
  localparam int EW = DATA_W + COUNT_W;
`ifdef SOC2_OCI_TRACE_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] dct_buffer = '0;
  logic [COUNT_W-1:0] dct_count = '0;
  logic              dct_valid = 1'b0;
  logic              test_ending = 1'b0;
  logic              test_has_ended = 1'b0;
  logic              rd_en = 1'b0;
  logic [EW-1:0]     rd_data;
  logic              rd_valid, empty, full, overflow;
  logic [4:0]        level;
  logic [1:0]        state;

  soc2_nios_oci_trace_monitor #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .level(level), .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a bounded queue plus the state rules.
  logic [EW-1:0] mq[$];
  int            m_state;
  logic          m_ovf, m_rv;
  logic [EW-1:0] m_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_state = 0;
    m_ovf = 1'b0;
    m_rv = 1'b0;
    m_rd = '0;
  endtask

  task automatic model_update();
    bit push, pop;
    push = dct_valid && (m_state <= 1) && !test_ending && !test_has_ended;
    pop = rd_en && (mq.size() > 0);
    m_rv = pop;
    if (pop) m_rd = mq.pop_front();
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back({dct_count, dct_buffer});
      else begin
        m_ovf = 1'b1;
        if (OVW) begin
          void'(mq.pop_front());
          mq.push_back({dct_count, dct_buffer});
        end
      end
    end
    if (test_has_ended && m_state != 3) m_state = 3;
    else if (test_ending && m_state <= 1) m_state = 2;
    else if (m_state == 0 && dct_valid) m_state = 1;
  endtask

  task automatic compare_model();
    check("state", 64'(state), 64'(m_state));
    check("level", 64'(level), 64'(mq.size()));
    check("empty", 64'(empty), 64'(mq.size() == 0));
    check("full", 64'(full), 64'(mq.size() == DEPTH));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("rd_valid", 64'(rd_valid), 64'(m_rv));
    check("rd_data", 64'(rd_data), 64'(m_rd));
  endtask

  task automatic set_in(input logic v, input logic [DATA_W-1:0] w, input logic [COUNT_W-1:0] c,
                        input logic rd, input logic te, input logic th);
    dct_valid = v; dct_buffer = w; dct_count = c; rd_en = rd; test_ending = te; test_has_ended = th;
  endtask

  // One clock: advance model on current inputs, then sample DUT 1ns after the edge.
  task automatic cycle();
    model_update();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    set_in(0, '0, '0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    compare_model();
  endtask

  typedef struct {
    logic v; logic [DATA_W-1:0] word; logic [COUNT_W-1:0] cnt; logic rd; logic te; logic th;
    logic [1:0] e_state; logic [4:0] e_level; logic e_rv; logic [EW-1:0] e_data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [EW-1:0] exp_d;
    int w;

    vecs[0] = '{1, 30'h1,  4'h1, 0, 0, 0, 2'd1, 5'd1, 0, 34'h0};
    vecs[1] = '{1, 30'h2,  4'h2, 0, 0, 0, 2'd1, 5'd2, 0, 34'h0};
    vecs[2] = '{1, 30'h3,  4'h3, 0, 0, 0, 2'd1, 5'd3, 0, 34'h0};
    vecs[3] = '{0, 30'h0,  4'h0, 1, 0, 0, 2'd1, 5'd2, 1, 34'h040000001};
    vecs[4] = '{0, 30'h0,  4'h0, 1, 0, 0, 2'd1, 5'd1, 1, 34'h080000002};
    vecs[5] = '{0, 30'h0,  4'h0, 1, 0, 0, 2'd1, 5'd0, 1, 34'h0C0000003};
    vecs[6] = '{0, 30'h0,  4'h0, 1, 0, 0, 2'd1, 5'd0, 0, 34'h0C0000003};
    vecs[7] = '{1, 30'h55, 4'h5, 0, 1, 0, 2'd2, 5'd0, 0, 34'h0C0000003};
    vecs[8] = '{1, 30'h66, 4'h6, 0, 0, 0, 2'd2, 5'd0, 0, 34'h0C0000003};
    vecs[9] = '{0, 30'h0,  4'h0, 0, 0, 1, 2'd3, 5'd0, 0, 34'h0C0000003};

    // Basic push/pop, empty read, end-of-test transitions
    do_reset();
    check("reset_state", 64'(state), 64'd0);
    check("reset_empty", 64'(empty), 64'd1);
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].v, vecs[i].word, vecs[i].cnt, vecs[i].rd, vecs[i].te, vecs[i].th);
      cycle();
      check($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].e_state));
      check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].e_level));
      check($sformatf("vec%0d_rv", i), 64'(rd_valid), 64'(vecs[i].e_rv));
      check($sformatf("vec%0d_data", i), 64'(rd_data), 64'(vecs[i].e_data));
    end
    check("vec_end_empty", 64'(empty), 64'd1);

    // 17 pushes into a 16-deep FIFO
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_in(1, DATA_W'(i), COUNT_W'(i), 0, 0, 0);
      cycle();
    end
    check("ovf17_overflow", 64'(overflow), 64'd1);
    check("ovf17_level", 64'(level), 64'd16);
    check("ovf17_full", 64'(full), 64'd1);
    for (int i = 0; i < 16; i++) begin
      set_in(0, '0, '0, 1, 0, 0);
      cycle();
      w = OVW ? i + 1 : i;
      exp_d = {COUNT_W'(w), DATA_W'(w)};
      check($sformatf("ovf17_pop%0d", i), 64'(rd_data), 64'(exp_d));
    end
    check("ovf17_empty", 64'(empty), 64'd1);

    // Full FIFO: push with simultaneous pop keeps level and does not overflow
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_in(1, DATA_W'(i), COUNT_W'(i), 0, 0, 0);
      cycle();
    end
    set_in(1, 30'hAA, 4'hA, 1, 0, 0);
    cycle();
    check("fullrw_level", 64'(level), 64'd16);
    check("fullrw_overflow", 64'(overflow), 64'd0);
    check("fullrw_first", 64'(rd_data), 64'({4'h0, 30'h0}));
    for (int i = 0; i < 16; i++) begin
      set_in(0, '0, '0, 1, 0, 0);
      cycle();
    end
    check("fullrw_last", 64'(rd_data), 64'({4'hA, 30'hAA}));

    // Drain after test_ending and test_has_ended
    do_reset();
    set_in(1, 30'h11, 4'h1, 0, 0, 0); cycle();
    set_in(1, 30'h22, 4'h2, 0, 0, 0); cycle();
    set_in(1, 30'h33, 4'h3, 0, 1, 0); cycle();
    check("drain_state", 64'(state), 64'd2);
    check("drain_level", 64'(level), 64'd2);
    set_in(0, '0, '0, 0, 0, 1); cycle();
    check("done_state", 64'(state), 64'd3);
    set_in(1, 30'h44, 4'h4, 1, 0, 0); cycle();
    check("done_pop1", 64'(rd_data), 64'({4'h1, 30'h11}));
    set_in(0, '0, '0, 1, 0, 0); cycle();
    check("done_pop2", 64'(rd_data), 64'({4'h2, 30'h22}));
    check("done_empty", 64'(empty), 64'd1);
    check("done_stays", 64'(state), 64'd3);

    // Asynchronous reset during capture with 5 entries held
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(1, DATA_W'(i + 7), COUNT_W'(i), 0, 0, 0);
      cycle();
    end
    set_in(0, '0, '0, 1, 0, 0); cycle();
    check("pre_arst_level", 64'(level), 64'd5);
    set_in(0, '0, '0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state", 64'(state), 64'd0);
    check("arst_level", 64'(level), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_full", 64'(full), 64'd0);
    check("arst_overflow", 64'(overflow), 64'd0);
    check("arst_rd_valid", 64'(rd_valid), 64'd0);
    check("arst_rd_data", 64'(rd_data), 64'd0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    set_in(1, 30'h5A, 4'h9, 0, 0, 0); cycle();
    check("post_arst_state", 64'(state), 64'd1);
    check("post_arst_level", 64'(level), 64'd1);
    set_in(0, '0, '0, 1, 0, 0); cycle();
    check("post_arst_pop", 64'(rd_data), 64'({4'h9, 30'h5A}));

    // Randomized episodes against the model
    for (int ep = 0; ep < 10; ep++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        set_in($urandom_range(0, 99) < 60, DATA_W'($urandom), COUNT_W'($urandom),
               $urandom_range(0, 99) < (ep % 2 == 0 ? 30 : 60),
               $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0);
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soc2_nios_oci_trace_monitor.md
SOC2_NIOS_OCI_TRACE_MONITOR -- requirements
Module: soc2_nios_oci_trace_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 30, width of dct_buffer.
REQ-002 SHALL have parameter COUNT_W, default 4, width of dct_count.
REQ-003 SHALL have parameter DEPTH, default 16, capture FIFO entries; power of two, 2..256.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port dct_buffer  input  DATA_W  trace word to capture.
REQ-007 SHALL have port dct_count  input  COUNT_W  tag stored with each word.
REQ-008 SHALL have port dct_valid  input  1  capture strobe for dct_buffer/dct_count.
REQ-009 SHALL have port test_ending  input  1  level; stop accepting captures.
REQ-010 SHALL have port test_has_ended  input  1  level; test complete.
REQ-011 SHALL have port rd_en  input  1  pop request.
REQ-012 SHALL have port rd_data  output  DATA_W+COUNT_W  {tag, word} of popped entry.
REQ-013 SHALL have port rd_valid  output  1  rd_data valid this cycle.
REQ-014 SHALL have port empty, full  output  1 each  FIFO status.
REQ-015 SHALL have port level  output  clog2(DEPTH)+1  current entry count.
REQ-016 SHALL have port overflow  output  1  sticky lost/overwritten-entry flag.
REQ-017 SHALL have port state  output  2  FSM state: 0 IDLE, 1 CAPTURE, 2 DRAIN, 3 DONE.

Function
REQ-018 SHALL leave IDLE for CAPTURE on the first cycle dct_valid=1; that word is captured.
REQ-019 SHALL push {dct_count, dct_buffer} on each clk where dct_valid=1 and state is IDLE or CAPTURE.
REQ-020 SHALL go from IDLE or CAPTURE to DRAIN when test_ending=1; test_ending wins over dct_valid the same cycle (no push).
REQ-021 SHALL go from any state except DONE to DONE when test_has_ended=1; DONE is left only by reset.
REQ-022 SHALL ignore dct_valid in DRAIN and DONE; pops remain allowed in all states.
REQ-023 SHALL pop when rd_en=1 and empty=0; rd_data/rd_valid registered, valid 1 cycle after rd_en.
REQ-024 SHALL hold rd_data and deassert rd_valid when rd_en=1 and empty=1.
REQ-025 SHALL perform push and pop in one cycle when both qualify, level unchanged, including when full.
REQ-026 SHALL update empty, full and level in the same cycle as the push/pop edge; read/write pointers wrap modulo DEPTH.
REQ-027 SHALL treat a push when full with no pop per REQ-045/046 and set overflow; overflow clears only on reset.

Reset
REQ-028 SHALL on reset_n=0 immediately force state=IDLE, level=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=0, pointers=0.
REQ-029 SHALL discard all FIFO contents on reset asserted mid-capture or mid-drain; first post-release edge behaves as from IDLE.

Configuration
REQ-045 SHALL, with macro SOC2_OCI_TRACE_OVERWRITE_EN defined, on push-when-full overwrite the oldest entry (advance both pointers), level stays DEPTH.
REQ-046 SHALL, without SOC2_OCI_TRACE_OVERWRITE_EN, on push-when-full drop the new word, contents and pointers unchanged.

Verification
REQ-050 SHALL cover: reset, 3 pushes 0x1/0x2/0x3 tags 1/2/3, then 3 pops -> rd_data {1,0x1},{2,0x2},{3,0x3} each 1 cycle after rd_en, empty=1 after.
REQ-051 SHALL cover: DEPTH=16, 17 pushes 0..16 -> overflow=1, level=16; pops return 0..15 (macro off) or 1..16 (macro on).
REQ-052 SHALL cover: full FIFO, push 0xAA with rd_en same cycle -> level stays 16, overflow=0, 0xAA last out.
REQ-053 SHALL cover: test_ending with dct_valid same cycle -> state=2, word not stored; later test_has_ended -> state=3; drain still works.
REQ-054 SHALL cover: reset_n low during CAPTURE with level=5 -> outputs at reset values asynchronously, no clk needed.
REQ-055 SHALL cover: rd_en on empty -> rd_valid=0, rd_data unchanged.
